// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI transfer sequencer: the FSM state encoding,
// the bit positions of the software control word and of the status word, and
// a small helper that resolves the fill-mode priority.
// -----------------------------------------------------------------------------
package spi_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_SEND   = 3'd3,
    ST_STORE  = 3'd4,
    ST_FINISH = 3'd5
  } state_e;

  // Control word (write side)
  localparam int SEND_BIT = 0;
  localparam int ALL1_BIT = 1;
  localparam int ALL0_BIT = 2;
  localparam int NTX_LSB  = 4;

  // Status word (read side)
  localparam int STAT_SEND_BIT = 0;
  localparam int STAT_BUSY_BIT = 1;
  localparam int STAT_ERR_BIT  = 2;
  localparam int STAT_DONE_BIT = 3;
  localparam int RXCNT_LSB     = 16;
  localparam int RXCNT_W       = 10;

  // All-ones fill wins over all-zeros fill when both are requested.
  function automatic logic fill_zero(input logic all1, input logic all0);
    return all0 & ~all1;
  endfunction

endpackage

// File: rtl/spi_done_edge.sv
// -----------------------------------------------------------------------------
// spi_done_edge
// Rising-edge detector for the SPI controller's byte-complete flag plus the
// per-byte timeout counter used while the sequencer waits in SEND.
//
// Ports:
//   clk_i, rst_i  clock, asynchronous active-high reset
//   done_i        byte-complete flag from the SPI controller (may be held high)
//   run_i         high while the sequencer is in SEND; low clears the counter
//   rise_o        done_i rose this cycle (done_i & ~previous done_i)
//   timeout_o     run_i has been high for TIMEOUT cycles with this one
// -----------------------------------------------------------------------------
module spi_done_edge #(
  parameter int TIMEOUT = 4096
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic done_i,
  input  logic run_i,
  output logic rise_o,
  output logic timeout_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic             prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next-state: previous done sample is refreshed every cycle; the counter only
  // runs in SEND, so any excursion out of SEND restarts it from zero.
  always_comb begin
    prev_d = done_i;
    if (run_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = '0;
    end
  end

  // State registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
    end
  end

  assign rise_o    = done_i & ~prev_q;
  // The first SEND cycle sees cnt_q == 0, so this fires on the TIMEOUT-th cycle.
  assign timeout_o = run_i & (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/spi_transfer_sequencer.sv
// -----------------------------------------------------------------------------
// spi_transfer_sequencer
// Walks a TX byte buffer for a block of n_tx_end+1 bytes, starts one SPI byte
// transfer per entry, waits for its completion (or a timeout) and writes each
// received byte into an RX byte buffer. Completion and the received-byte count
// are reported in a status word.
//
// Ports:
//   clk_i, rst_i         clock, asynchronous active-high reset
//   ctrl_we_i/_wdata_i   control write: [0] send, [1] all_1s, [2] all_0s,
//                        [4+:ADDR_W] n_tx_end (ignored while busy)
//   ctrl_o               status: [0] send, [1] busy, [2] err, [3] done,
//                        [16+:10] n_rx_end
//   tx_addr_o/tx_rdata_i TX buffer read port (data one cycle after address)
//   rx_we_o/_addr_o/_wdata_o  RX buffer write port
//   spi_send_o, spi_tx_data_o, spi_all_1s_o, spi_all_0s_o  to SPI controller
//   spi_tx_done_i, spi_rx_data_i                           from SPI controller
//   done_o               one-cycle pulse at the end of a block
// -----------------------------------------------------------------------------
module spi_transfer_sequencer
  import spi_pkg::*;
#(
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ctrl_we_i,
  input  logic [31:0]       ctrl_wdata_i,
  output logic [31:0]       ctrl_o,
  output logic [ADDR_W-1:0] tx_addr_o,
  input  logic [7:0]        tx_rdata_i,
  output logic              rx_we_o,
  output logic [ADDR_W-1:0] rx_addr_o,
  output logic [7:0]        rx_wdata_o,
  output logic              spi_send_o,
  output logic [7:0]        spi_tx_data_o,
  output logic              spi_all_1s_o,
  output logic              spi_all_0s_o,
  input  logic              spi_tx_done_i,
  input  logic [7:0]        spi_rx_data_i,
  output logic              done_o
);

  // One extra bit so a full 2^ADDR_W block can be counted.
  localparam int CNT_W = ADDR_W + 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] n_tx_end_q, n_tx_end_d;
  logic [CNT_W-1:0]  n_rx_q, n_rx_d;
  logic              all1_q, all1_d;
  logic              all0_q, all0_d;
  logic              busy_q, busy_d;
  logic              send_bit_q, send_bit_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              done_pulse_q, done_pulse_d;
  logic              spi_send_q, spi_send_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              rx_we_q, rx_we_d;
  logic [7:0]        rx_wdata_q, rx_wdata_d;

  logic              done_rise_s;
  logic              timeout_s;
  logic              unused_ctrl_bits;

  assign unused_ctrl_bits = ^{ctrl_wdata_i[3], ctrl_wdata_i[31:NTX_LSB+ADDR_W]};

  spi_done_edge #(
    .TIMEOUT (TIMEOUT)
  ) u_done_edge (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .done_i    (spi_tx_done_i),
    .run_i     (state_q == ST_SEND),
    .rise_o    (done_rise_s),
    .timeout_o (timeout_s)
  );

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    n_tx_end_d   = n_tx_end_q;
    n_rx_d       = n_rx_q;
    all1_d       = all1_q;
    all0_d       = all0_q;
    busy_d       = busy_q;
    send_bit_d   = send_bit_q;
    err_d        = err_q;
    done_d       = done_q;
    tx_data_d    = tx_data_q;
    rx_wdata_d   = rx_wdata_q;
    done_pulse_d = 1'b0;
    spi_send_d   = 1'b0;
    rx_we_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Control writes are only honoured here; while busy they are dropped.
        if (ctrl_we_i && ctrl_wdata_i[SEND_BIT]) begin
          n_tx_end_d = ctrl_wdata_i[NTX_LSB +: ADDR_W];
          all1_d     = ctrl_wdata_i[ALL1_BIT];
          all0_d     = fill_zero(ctrl_wdata_i[ALL1_BIT], ctrl_wdata_i[ALL0_BIT]);
          idx_d      = '0;
          n_rx_d     = '0;
          err_d      = 1'b0;
          done_d     = 1'b0;
          busy_d     = 1'b1;
          send_bit_d = 1'b1;
          state_d    = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_FETCH: begin
        state_d = ST_LOAD;
      end

      ST_LOAD: begin
        // Buffer data for idx is valid now; send goes high with the data.
        tx_data_d  = tx_rdata_i;
        spi_send_d = 1'b1;
        state_d    = ST_SEND;
      end

      ST_SEND: begin
        if (done_rise_s) begin
          rx_wdata_d = spi_rx_data_i;
          rx_we_d    = 1'b1;
          state_d    = ST_STORE;
        end else if (timeout_s) begin
          err_d        = 1'b1;
          busy_d       = 1'b0;
          send_bit_d   = 1'b0;
          done_d       = 1'b1;
          done_pulse_d = 1'b1;
          state_d      = ST_FINISH;
        end else begin
          spi_send_d = 1'b1;
          state_d    = ST_SEND;
        end
      end

      ST_STORE: begin
        n_rx_d = n_rx_q + CNT_W'(1);
        // Compare before incrementing so an all-ones n_tx_end never wraps idx.
        if (idx_q == n_tx_end_q) begin
          busy_d       = 1'b0;
          send_bit_d   = 1'b0;
          done_d       = 1'b1;
          done_pulse_d = 1'b1;
          state_d      = ST_FINISH;
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = ST_FETCH;
        end
      end

      ST_FINISH: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      n_tx_end_q   <= '0;
      n_rx_q       <= '0;
      all1_q       <= 1'b0;
      all0_q       <= 1'b0;
      busy_q       <= 1'b0;
      send_bit_q   <= 1'b0;
      err_q        <= 1'b0;
      done_q       <= 1'b0;
      done_pulse_q <= 1'b0;
      spi_send_q   <= 1'b0;
      tx_data_q    <= 8'h00;
      rx_we_q      <= 1'b0;
      rx_wdata_q   <= 8'h00;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      n_tx_end_q   <= n_tx_end_d;
      n_rx_q       <= n_rx_d;
      all1_q       <= all1_d;
      all0_q       <= all0_d;
      busy_q       <= busy_d;
      send_bit_q   <= send_bit_d;
      err_q        <= err_d;
      done_q       <= done_d;
      done_pulse_q <= done_pulse_d;
      spi_send_q   <= spi_send_d;
      tx_data_q    <= tx_data_d;
      rx_we_q      <= rx_we_d;
      rx_wdata_q   <= rx_wdata_d;
    end
  end

  // Status word packing.
  always_comb begin
    ctrl_o                          = 32'd0;
    ctrl_o[STAT_SEND_BIT]           = send_bit_q;
    ctrl_o[STAT_BUSY_BIT]           = busy_q;
    ctrl_o[STAT_ERR_BIT]            = err_q;
    ctrl_o[STAT_DONE_BIT]           = done_q;
    ctrl_o[RXCNT_LSB +: RXCNT_W]    = RXCNT_W'(n_rx_q);
  end

  assign tx_addr_o     = idx_q;
  assign rx_addr_o     = idx_q;
  assign rx_we_o       = rx_we_q;
  assign rx_wdata_o    = rx_wdata_q;
  assign spi_send_o    = spi_send_q;
  assign spi_tx_data_o = tx_data_q;
  assign spi_all_1s_o  = all1_q;
  assign spi_all_0s_o  = all0_q;
  assign done_o        = done_pulse_q;

endmodule

// File: tb/tb_spi_transfer_sequencer.sv
module tb_spi_transfer_sequencer;

  localparam int ADDR_W  = 9;
  localparam int TIMEOUT = 16;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              ctrl_we_i;
  logic [31:0]       ctrl_wdata_i;
  logic [31:0]       ctrl_o;
  logic [ADDR_W-1:0] tx_addr_o;
  logic [7:0]        tx_rdata_i;
  logic              rx_we_o;
  logic [ADDR_W-1:0] rx_addr_o;
  logic [7:0]        rx_wdata_o;
  logic              spi_send_o;
  logic [7:0]        spi_tx_data_o;
  logic              spi_all_1s_o;
  logic              spi_all_0s_o;
  logic              spi_tx_done_i;
  logic [7:0]        spi_rx_data_i;
  logic              done_o;

  spi_transfer_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .ctrl_we_i(ctrl_we_i), .ctrl_wdata_i(ctrl_wdata_i),
    .ctrl_o(ctrl_o), .tx_addr_o(tx_addr_o), .tx_rdata_i(tx_rdata_i), .rx_we_o(rx_we_o),
    .rx_addr_o(rx_addr_o), .rx_wdata_o(rx_wdata_o), .spi_send_o(spi_send_o),
    .spi_tx_data_o(spi_tx_data_o), .spi_all_1s_o(spi_all_1s_o), .spi_all_0s_o(spi_all_0s_o),
    .spi_tx_done_i(spi_tx_done_i), .spi_rx_data_i(spi_rx_data_i), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  int n_pass = 0;
  int n_total = 0;

  // TX buffer: synchronous read, data one cycle after the address.
  logic [7:0] tx_mem [0:511];
  always @(posedge clk_i) tx_rdata_i <= tx_mem[tx_addr_o];

  // SPI controller model knobs (written only by the main sequence).
  int         mode = 0;        // 0: reply ~tx, 1: reply fixed_resp, 2: random reply
  logic [7:0] fixed_resp = 8'h00;
  int         hang_idx = -1;   // block-relative byte that never completes
  int         max_dly = 5;
  int         sent_base = 0;

  // Written only by the model.
  logic [7:0] sent_q [$];
  logic [7:0] resp_q [$];

  // Written only by the monitor.
  logic [16:0] rx_log [$];
  int          gap_q [$];
  int          done_cnt = 0;
  int          gap_run = 0;
  bit          had_high = 1'b0;

  // SPI controller model: reacts to send, replies after a random delay and
  // holds done high for a random number of cycles.
  initial begin : spi_model
    logic [7:0] b;
    logic [7:0] r;
    int d;
    int h;
    spi_tx_done_i = 1'b0;
    spi_rx_data_i = 8'h00;
    forever begin
      @(negedge clk_i);
      if (spi_send_o === 1'b1) begin
        b = spi_tx_data_o;
        sent_q.push_back(b);
        if ((sent_q.size() - 1 - sent_base) == hang_idx) begin
          while (spi_send_o === 1'b1) @(negedge clk_i);
        end else begin
          d = $urandom_range(0, max_dly);
          repeat (d) @(negedge clk_i);
          case (mode)
            0: r = ~b;
            1: r = fixed_resp;
            default: r = 8'($urandom);
          endcase
          resp_q.push_back(r);
          spi_rx_data_i = r;
          spi_tx_done_i = 1'b1;
          h = $urandom_range(1, 8);
          repeat (h) @(negedge clk_i);
          spi_tx_done_i = 1'b0;
        end
      end
    end
  end

  // Output monitor: RX writes, done pulses and send-low gaps within a block.
  always @(negedge clk_i) begin
    if (rx_we_o === 1'b1) rx_log.push_back({rx_addr_o, rx_wdata_o});
    if (done_o === 1'b1) done_cnt++;
    if (ctrl_o[1] !== 1'b1) begin
      had_high = 1'b0;
      gap_run  = 0;
    end else if (spi_send_o === 1'b1) begin
      if (had_high && gap_run > 0) gap_q.push_back(gap_run);
      had_high = 1'b1;
      gap_run  = 0;
    end else begin
      gap_run++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic start_block(input int n_end, input bit a1, input bit a0);
    @(negedge clk_i);
    ctrl_wdata_i = 32'd0;
    ctrl_wdata_i[0] = 1'b1;
    ctrl_wdata_i[1] = a1;
    ctrl_wdata_i[2] = a0;
    ctrl_wdata_i[4 +: 9] = n_end[8:0];
    ctrl_we_i = 1'b1;
    @(negedge clk_i);
    ctrl_we_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen, output bit busy_at_done);
    seen = 1'b0;
    busy_at_done = 1'b1;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk_i);
      if (done_o === 1'b1) begin
        seen = 1'b1;
        busy_at_done = ctrl_o[1];
      end
    end
    @(negedge clk_i);
  endtask

  task automatic fill_tx(input int n);
    for (int i = 0; i <= n; i++) tx_mem[i] = 8'($urandom);
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    ctrl_we_i = 1'b0;
    ctrl_wdata_i = 32'd0;
    repeat (3) @(negedge clk_i);
    n_total++;
    if ({spi_send_o, rx_we_o, done_o, spi_all_1s_o, spi_all_0s_o} !== 5'b0) $display("FAIL reset_flags: got %b expected 00000", {spi_send_o, rx_we_o, done_o, spi_all_1s_o, spi_all_0s_o}); else n_pass++;
    n_total++;
    if ({tx_addr_o, rx_addr_o, rx_wdata_o, spi_tx_data_o} !== 34'd0) $display("FAIL reset_data: got %h expected 0", {tx_addr_o, rx_addr_o, rx_wdata_o, spi_tx_data_o}); else n_pass++;
    rst_i = 1'b0;
    @(negedge clk_i);
    n_total++;
    if (ctrl_o !== 32'd0) $display("FAIL reset_status: got %h expected 0", ctrl_o); else n_pass++;
  endtask

  task automatic test_single_byte();
    bit seen, busy_d;
    int lb, db;
    lb = rx_log.size(); db = done_cnt;
    tx_mem[0] = 8'hA5; mode = 1; fixed_resp = 8'h3C; hang_idx = -1;
    sent_base = sent_q.size();
    start_block(0, 1'b0, 1'b0);
    n_total++;
    if (tx_addr_o !== 9'd0 || ctrl_o[1] !== 1'b1) $display("FAIL single_cycle1: addr %h busy %b expected 0/1", tx_addr_o, ctrl_o[1]); else n_pass++;
    @(negedge clk_i);
    n_total++;
    if (spi_send_o !== 1'b0) $display("FAIL single_cycle2_send: got %b expected 0", spi_send_o); else n_pass++;
    @(negedge clk_i);
    n_total++;
    if (spi_send_o !== 1'b1 || spi_tx_data_o !== 8'hA5) $display("FAIL single_cycle3: send %b data %h expected 1/a5", spi_send_o, spi_tx_data_o); else n_pass++;
    wait_done(200, seen, busy_d);
    n_total++;
    if (!seen || busy_d !== 1'b0) $display("FAIL single_done: seen %b busy %b expected 1/0", seen, busy_d); else n_pass++;
    n_total++;
    if (rx_log.size() - lb != 1 || rx_log[lb] !== {9'd0, 8'h3C}) $display("FAIL single_rx: writes %0d expected 1 (data 03c)", rx_log.size() - lb); else n_pass++;
    n_total++;
    if (done_cnt - db != 1 || done_o !== 1'b0) $display("FAIL single_pulse: pulses %0d done_o %b expected 1/0", done_cnt - db, done_o); else n_pass++;
    n_total++;
    if (ctrl_o !== 32'h0001_0008) $display("FAIL single_status: got %h expected 00010008", ctrl_o); else n_pass++;
  endtask

  task automatic test_four_bytes();
    bit seen, busy_d;
    int lb, gb, mg;
    logic [7:0] pat [4];
    pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33; pat[3] = 8'h44;
    for (int i = 0; i < 4; i++) tx_mem[i] = pat[i];
    lb = rx_log.size(); gb = gap_q.size();
    mode = 0; hang_idx = -1; sent_base = sent_q.size();
    start_block(3, 1'b0, 1'b0);
    wait_done(400, seen, busy_d);
    n_total++;
    if (!seen || rx_log.size() - lb != 4) $display("FAIL four_writes: seen %b writes %0d expected 1/4", seen, rx_log.size() - lb); else n_pass++;
    for (int i = 0; i < 4 && rx_log.size() - lb == 4; i++) begin
      n_total++;
      if (rx_log[lb+i] !== {i[8:0], ~pat[i]}) $display("FAIL four_rx%0d: got %h expected %h", i, rx_log[lb+i], {i[8:0], ~pat[i]}); else n_pass++;
    end
    mg = 1000;
    for (int i = gb; i < gap_q.size(); i++) if (gap_q[i] < mg) mg = gap_q[i];
    n_total++;
    if (gap_q.size() - gb != 3 || mg < 2) $display("FAIL four_gap: gaps %0d min %0d expected 3 gaps >=2", gap_q.size() - gb, mg); else n_pass++;
    n_total++;
    if (ctrl_o[25:16] !== 10'd4 || ctrl_o[2] !== 1'b0) $display("FAIL four_status: n_rx %0d err %b expected 4/0", ctrl_o[25:16], ctrl_o[2]); else n_pass++;
  endtask

  task automatic test_fill_mode();
    bit seen, busy_d;
    int lb, rb;
    fill_tx(2);
    lb = rx_log.size(); rb = resp_q.size();
    mode = 2; hang_idx = -1; sent_base = sent_q.size();
    start_block(2, 1'b1, 1'b1);
    n_total++;
    if (spi_all_1s_o !== 1'b1 || spi_all_0s_o !== 1'b0) $display("FAIL fill_flags: got %b%b expected 10", spi_all_1s_o, spi_all_0s_o); else n_pass++;
    wait_done(400, seen, busy_d);
    n_total++;
    if (!seen || rx_log.size() - lb != 3) $display("FAIL fill_writes: seen %b writes %0d expected 1/3", seen, rx_log.size() - lb); else n_pass++;
    for (int i = 0; i < 3 && rx_log.size() - lb == 3; i++) begin
      n_total++;
      if (rx_log[lb+i] !== {i[8:0], resp_q[rb+i]} || sent_q[sent_base+i] !== tx_mem[i]) $display("FAIL fill_byte%0d: rx %h sent %h expected %h/%h", i, rx_log[lb+i], sent_q[sent_base+i], {i[8:0], resp_q[rb+i]}, tx_mem[i]); else n_pass++;
    end
  endtask

  task automatic test_busy_reject();
    bit seen, busy_d;
    int lb, db;
    fill_tx(3);
    lb = rx_log.size(); db = done_cnt;
    mode = 0; hang_idx = -1; sent_base = sent_q.size();
    start_block(3, 1'b0, 1'b0);
    repeat (5) @(negedge clk_i);
    ctrl_wdata_i = 32'h0000_0077;   // send, all_1s, all_0s, n_tx_end = 7
    ctrl_we_i = 1'b1;
    @(negedge clk_i);
    ctrl_we_i = 1'b0;
    n_total++;
    if (spi_all_1s_o !== 1'b0 || spi_all_0s_o !== 1'b0) $display("FAIL busy_flags: got %b%b expected 00", spi_all_1s_o, spi_all_0s_o); else n_pass++;
    wait_done(600, seen, busy_d);
    repeat (40) @(negedge clk_i);
    n_total++;
    if (!seen || rx_log.size() - lb != 4 || done_cnt - db != 1) $display("FAIL busy_len: writes %0d pulses %0d expected 4/1", rx_log.size() - lb, done_cnt - db); else n_pass++;
    n_total++;
    if (ctrl_o[25:16] !== 10'd4) $display("FAIL busy_nrx: got %0d expected 4", ctrl_o[25:16]); else n_pass++;
  endtask

  task automatic test_timeout();
    bit seen, busy_d;
    int lb, db;
    fill_tx(3);
    lb = rx_log.size(); db = done_cnt;
    mode = 2; hang_idx = 1; sent_base = sent_q.size();
    start_block(3, 1'b0, 1'b0);
    wait_done(300, seen, busy_d);
    n_total++;
    if (!seen || done_cnt - db != 1) $display("FAIL timeout_pulse: seen %b pulses %0d expected 1/1", seen, done_cnt - db); else n_pass++;
    n_total++;
    if (rx_log.size() - lb != 1 || rx_log[lb][16:8] !== 9'd0) $display("FAIL timeout_writes: got %0d writes expected 1 at addr 0", rx_log.size() - lb); else n_pass++;
    n_total++;
    if (ctrl_o !== 32'h0001_000C || spi_send_o !== 1'b0) $display("FAIL timeout_status: got %h send %b expected 0001000c/0", ctrl_o, spi_send_o); else n_pass++;
    hang_idx = -1;
  endtask

  task automatic test_reset_mid();
    bit found;
    int lb, db;
    fill_tx(4);
    lb = rx_log.size(); db = done_cnt;
    mode = 0; hang_idx = 2; sent_base = sent_q.size();
    start_block(4, 1'b1, 1'b0);
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk_i);
      if (sent_q.size() - sent_base >= 3 && spi_send_o === 1'b1) found = 1'b1;
    end
    n_total++;
    if (!found) $display("FAIL rstmid_reach: byte 2 send not seen, got 0 expected 1"); else n_pass++;
    rst_i = 1'b1;
    @(negedge clk_i);
    n_total++;
    if ({spi_send_o, rx_we_o, done_o, spi_all_1s_o, tx_addr_o, spi_tx_data_o, ctrl_o} !== 51'd0) $display("FAIL rstmid_outputs: got %h expected 0", {spi_send_o, rx_we_o, done_o, spi_all_1s_o, tx_addr_o, spi_tx_data_o, ctrl_o}); else n_pass++;
    rst_i = 1'b0;
    repeat (30) @(negedge clk_i);
    n_total++;
    if (rx_log.size() - lb != 2 || done_cnt - db != 0) $display("FAIL rstmid_after: writes %0d pulses %0d expected 2/0", rx_log.size() - lb, done_cnt - db); else n_pass++;
    hang_idx = -1;
  endtask

  task automatic test_random_blocks();
    bit seen, busy_d, a1, a0;
    int lb, rb, n, errs;
    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(0, 20);
      a1 = 1'($urandom); a0 = 1'($urandom);
      fill_tx(n);
      lb = rx_log.size(); rb = resp_q.size();
      mode = $urandom_range(0, 2); hang_idx = -1; sent_base = sent_q.size();
      start_block(n, a1, a0);
      n_total++;
      if (spi_all_1s_o !== a1 || spi_all_0s_o !== (a0 & ~a1)) $display("FAIL rand%0d_flags: got %b%b expected %b%b", it, spi_all_1s_o, spi_all_0s_o, a1, a0 & ~a1); else n_pass++;
      wait_done(1000, seen, busy_d);
      errs = 0;
      if (!seen || rx_log.size() - lb != n + 1) errs++;
      for (int i = 0; i <= n && rx_log.size() - lb == n + 1; i++)
        if (rx_log[lb+i] !== {i[8:0], resp_q[rb+i]} || sent_q[sent_base+i] !== tx_mem[i]) errs++;
      n_total++;
      if (errs != 0) $display("FAIL rand%0d_data: got %0d bad bytes of %0d expected 0", it, errs, n + 1); else n_pass++;
      n_total++;
      if (ctrl_o[25:16] !== 10'(n + 1)) $display("FAIL rand%0d_nrx: got %0d expected %0d", it, ctrl_o[25:16], n + 1); else n_pass++;
    end
  endtask

  task automatic test_max_length();
    bit seen, busy_d;
    int lb, errs;
    fill_tx(511);
    lb = rx_log.size();
    mode = 0; hang_idx = -1; max_dly = 1; sent_base = sent_q.size();
    start_block(511, 1'b0, 1'b0);
    wait_done(20000, seen, busy_d);
    errs = 0;
    for (int i = 0; i < 512 && rx_log.size() - lb == 512; i++)
      if (rx_log[lb+i] !== {i[8:0], ~tx_mem[i]}) errs++;
    n_total++;
    if (!seen || rx_log.size() - lb != 512 || errs != 0) $display("FAIL max_data: seen %b writes %0d bad %0d expected 1/512/0", seen, rx_log.size() - lb, errs); else n_pass++;
    n_total++;
    if (ctrl_o[25:16] !== 10'd512 || ctrl_o[3:0] !== 4'b1000) $display("FAIL max_status: n_rx %0d flags %b expected 512/1000", ctrl_o[25:16], ctrl_o[3:0]); else n_pass++;
    max_dly = 5;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) tx_mem[i] = 8'h00;
    test_reset();
    test_single_byte();
    test_four_bytes();
    test_fill_mode();
    test_busy_reject();
    test_timeout();
    test_reset_mid();
    test_random_blocks();
    test_max_length();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
